// File: rtl/xc_malu_pkg.sv
// Shared definitions for the MALU multiplier controller and step datapath.
package xc_malu_pkg;

  localparam int XLEN      = 32;
  localparam int MUL_ACC_W = 64;
  localparam int PW_W      = 5;

  // Bit positions within the one-hot packed-width vector.
  localparam int PW_2  = 0;
  localparam int PW_4  = 1;
  localparam int PW_8  = 2;
  localparam int PW_16 = 3;
  localparam int PW_32 = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [PW_W-1:0] pw;
    logic            carryless;
    logic            lhs_sign;
    logic            rhs_sign;
    logic            hi;
  } mul_req_t;

  function automatic logic [XLEN-1:0] acc_half(input logic [MUL_ACC_W-1:0] acc,
                                               input logic hi);
    return hi ? acc[MUL_ACC_W-1:XLEN] : acc[XLEN-1:0];
  endfunction

endpackage

// File: rtl/xc_malu_mul_ctrl.sv
// Sequencing controller for the iterative multiplier: owns the step state and
// feeds it to the combinational step datapath until that datapath reports ready.
module xc_malu_mul_ctrl
  import xc_malu_pkg::*;
#(
    parameter int MAX_STEPS = 32
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [XLEN-1:0]      req_rs1,
    input  logic [XLEN-1:0]      req_rs2,
    input  logic [PW_W-1:0]      req_pw,
    input  logic                 req_carryless,
    input  logic                 req_lhs_sign,
    input  logic                 req_rhs_sign,
    input  logic                 req_hi,
    output logic [XLEN-1:0]      step_rs1,
    output logic [XLEN-1:0]      step_rs2,
    output logic [PW_W-1:0]      step_pw,
    output logic                 step_carryless,
    output logic                 step_lhs_sign,
    output logic                 step_rhs_sign,
    output logic [5:0]           step_count,
    output logic [MUL_ACC_W-1:0] step_acc,
    output logic [XLEN-1:0]      step_arg_0,
    input  logic [MUL_ACC_W-1:0] step_n_acc,
    input  logic [XLEN-1:0]      step_n_arg_0,
    input  logic                 step_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [XLEN-1:0]      rsp_result,
    output logic                 rsp_err
);

    localparam logic [5:0] LAST_STEP = 6'(MAX_STEPS - 1);

    mul_state_t state_q, state_d;
    mul_req_t   op_q;

    logic at_last;
    assign at_last = (step_count == LAST_STEP);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (req_valid)              state_d = ST_RUN;
                ST_RUN:  if (step_ready || at_last)  state_d = ST_DONE;
                ST_DONE: if (rsp_ready)              state_d = ST_IDLE;
                default:                             state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE) && !flush;
        rsp_valid = (state_q == ST_DONE);
    end

    // step_ready wins over the step ceiling: the current acc is already final.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            op_q       <= '0;
            step_count <= '0;
            step_acc   <= '0;
            step_arg_0 <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else if (flush) begin
            step_count <= '0;
            step_acc   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q       <= '{rs1: req_rs1, rs2: req_rs2, pw: req_pw,
                                        carryless: req_carryless,
                                        lhs_sign: req_lhs_sign,
                                        rhs_sign: req_rhs_sign, hi: req_hi};
                        step_acc   <= '0;
                        step_arg_0 <= req_rs2;
                        step_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (step_ready) begin
                        rsp_result <= acc_half(step_acc, op_q.hi);
                        rsp_err    <= 1'b0;
                    end else if (at_last) begin
                        rsp_result <= acc_half(step_n_acc, op_q.hi);
                        rsp_err    <= 1'b1;
                    end else begin
                        step_acc   <= step_n_acc;
                        step_arg_0 <= step_n_arg_0;
                        step_count <= step_count + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign step_rs1       = op_q.rs1;
    assign step_rs2       = op_q.rs2;
    assign step_pw        = op_q.pw;
    assign step_carryless = op_q.carryless;
    assign step_lhs_sign  = op_q.lhs_sign;
    assign step_rhs_sign  = op_q.rhs_sign;

endmodule

// File: tb/tb_xc_malu_mul_ctrl.sv
// Bench for xc_malu_mul_ctrl: a stateless shift-add step model stands in for the
// datapath, and results are predicted as rs1 * (low k bits of rs2).
module tb_xc_malu_mul_ctrl;
  import xc_malu_pkg::*;

  localparam int MAX = 32;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_rs1 = '0, req_rs2 = '0;
  logic [4:0]  req_pw = '0;
  logic        req_carryless = 1'b0, req_lhs_sign = 1'b0, req_rhs_sign = 1'b0, req_hi = 1'b0;
  logic [31:0] step_rs1, step_rs2;
  logic [4:0]  step_pw;
  logic        step_carryless, step_lhs_sign, step_rhs_sign;
  logic [5:0]  step_count;
  logic [63:0] step_acc, step_n_acc;
  logic [31:0] step_arg_0, step_n_arg_0;
  logic        step_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_err;

  int total = 0;
  int bad = 0;
  int ready_at = 99;

  always #5 g_clk = ~g_clk;

  xc_malu_mul_ctrl #(.MAX_STEPS(MAX)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pw(req_pw),
    .req_carryless(req_carryless), .req_lhs_sign(req_lhs_sign),
    .req_rhs_sign(req_rhs_sign), .req_hi(req_hi),
    .step_rs1(step_rs1), .step_rs2(step_rs2), .step_pw(step_pw),
    .step_carryless(step_carryless), .step_lhs_sign(step_lhs_sign),
    .step_rhs_sign(step_rhs_sign), .step_count(step_count),
    .step_acc(step_acc), .step_arg_0(step_arg_0),
    .step_n_acc(step_n_acc), .step_n_arg_0(step_n_arg_0),
    .step_ready(step_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  // Unsigned shift-add step; the datapath declares the state final at step ready_at.
  always_comb begin
    step_n_acc   = step_acc + (step_arg_0[0] ? ({32'b0, step_rs1} << step_count) : 64'd0);
    step_n_arg_0 = step_arg_0 >> 1;
    step_ready   = (int'(step_count) == ready_at);
  end

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input int k, input logic hi);
    logic [63:0] mask, p;
    mask = (64'd1 << k) - 64'd1;
    p = {32'b0, a} * ({32'b0, b} & mask);
    return hi ? p[63:32] : p[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the caller at the falling edge just after the accept edge.
  task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic hi);
    int n;
    n = 0;
    @(negedge g_clk);
    req_rs1 = a; req_rs2 = b; req_hi = hi; req_pw = 5'b10000;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge g_clk);
      n++;
    end
    chk("req_ready_wait", 64'(n < 50), 64'd1);
    @(negedge g_clk);
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp(input logic [31:0] exp_res, input logic exp_err,
                            input int exp_lat, input int hold);
    int lat;
    logic [31:0] held;
    lat = 0;
    while (!rsp_valid && lat < 200) begin
      @(negedge g_clk);
      lat++;
    end
    chk("rsp_latency", 64'(lat), 64'(exp_lat));
    chk("rsp_result", 64'(rsp_result), 64'(exp_res));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    held = rsp_result;
    for (int i = 0; i < hold; i++) begin
      @(negedge g_clk);
      chk("done_hold_result", 64'(rsp_result), 64'(held));
      chk("done_hold_valid", 64'(rsp_valid), 64'd1);
      chk("done_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge g_clk);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_rsp_req_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_step_count"}, 64'(step_count), 64'd0);
    chk({tag, "_step_acc"}, step_acc, 64'd0);
    chk({tag, "_step_arg_0"}, 64'(step_arg_0), 64'd0);
    chk({tag, "_step_rs1"}, 64'(step_rs1), 64'd0);
    chk({tag, "_step_pw"}, 64'(step_pw), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        hi;
    int          k;

    #12;
    check_reset_vals("reset");
    @(negedge g_clk);
    g_resetn = 1'b1;

    // 3*5 with the datapath only ready at the last legal step.
    ready_at = MAX - 1;
    start_req(32'd3, 32'd5, 1'b0);
    finish_rsp(32'd15, 1'b0, MAX, 0);

    // Ready immediately: result is the untouched zero accumulator.
    ready_at = 0;
    start_req(32'hdead_beef, 32'h1234_5678, 1'b0);
    finish_rsp(32'd0, 1'b0, 1, 0);

    // Never ready: ceiling hit, result comes from the final n_acc, err set.
    ready_at = 99;
    start_req(32'hffff_ffff, 32'h0000_0002, 1'b1);
    finish_rsp(ref_mul(32'hffff_ffff, 32'h2, MAX, 1'b1), 1'b1, MAX, 0);

    // Hold the response for ten cycles with rsp_ready low.
    ready_at = 16;
    start_req(32'h0001_0003, 32'h0000_ff07, 1'b0);
    finish_rsp(ref_mul(32'h0001_0003, 32'h0000_ff07, 16, 1'b0), 1'b0, 17, 10);

    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; hi = 1'($urandom_range(0, 1));
      k = $urandom_range(0, MAX - 1);
      ready_at = k;
      start_req(a, b, hi);
      finish_rsp(ref_mul(a, b, k, hi), 1'b0, k + 1, 0);
    end

    // Flush at RUN step 7.
    ready_at = 20;
    start_req(32'h55, 32'hff, 1'b0);
    while (step_count != 6'd7 && !rsp_valid) @(negedge g_clk);
    chk("flush_at_step", 64'(step_count), 64'd7);
    flush = 1'b1;
    #1;
    chk("flush_req_ready", 64'(req_ready), 64'd0);
    @(negedge g_clk);
    flush = 1'b0;
    #1;
    chk("flush_idle_req_ready", 64'(req_ready), 64'd1);
    chk("flush_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("flush_step_count", 64'(step_count), 64'd0);
    chk("flush_step_acc", step_acc, 64'd0);
    chk("flush_keeps_rs1", 64'(step_rs1), 64'h55);
    ready_at = 8;
    start_req(32'd7, 32'd6, 1'b0);
    finish_rsp(32'd42, 1'b0, 9, 0);

    // Asynchronous reset mid-RUN.
    ready_at = 25;
    start_req(32'h1234, 32'hffff, 1'b1);
    repeat (4) @(negedge g_clk);
    #2;
    g_resetn = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    @(negedge g_clk);
    g_resetn = 1'b1;
    repeat (30) @(negedge g_clk);
    chk("no_rsp_after_reset", 64'(rsp_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
